// File: rtl/dbus_uncache_resp_if.sv
// dbus_uncache_resp_if: CPU-side request/response and memory-side read/write channels of the uncached data-bus responder.
interface dbus_uncache_resp_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_valid;
    logic              cpu_op;
    logic [ADDR_W-1:0] cpu_addr;
    logic [1:0]        cpu_size;
    logic [3:0]        cpu_wstrb;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_flush;
    logic              cpu_busy;
    logic              cpu_data_ok;
    logic [DATA_W-1:0] cpu_rdata;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_size;
    logic              rd_rdy;
    logic              ret_valid;
    logic [DATA_W-1:0] ret_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_size;
    logic [3:0]        wr_strb;
    logic [DATA_W-1:0] wr_data;
    logic              wr_rdy;
    logic              wr_done;

    modport slave (
        input  cpu_valid, cpu_op, cpu_addr, cpu_size, cpu_wstrb, cpu_wdata, cpu_flush,
        output cpu_busy, cpu_data_ok, cpu_rdata,
        output rd_req, rd_addr, rd_size,
        input  rd_rdy, ret_valid, ret_data,
        output wr_req, wr_addr, wr_size, wr_strb, wr_data,
        input  wr_rdy, wr_done
    );

    modport master (
        output cpu_valid, cpu_op, cpu_addr, cpu_size, cpu_wstrb, cpu_wdata, cpu_flush,
        input  cpu_busy, cpu_data_ok, cpu_rdata,
        input  rd_req, rd_addr, rd_size,
        output rd_rdy, ret_valid, ret_data,
        input  wr_req, wr_addr, wr_size, wr_strb, wr_data,
        output wr_rdy, wr_done
    );
endinterface

// File: rtl/dbus_uncache_resp.sv
// dbus_uncache_resp: uncached load/store responder turning CPU requests into single-beat memory transactions.
// Define UNCACHE_WBUF_EN to add a one-entry posted-write buffer.
module dbus_uncache_resp #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic resetn,
    dbus_uncache_resp_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [3:0]        strb_q, strb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              kill_q, kill_d, ok_q, ok_d;
    logic              wb_req_q, wb_req_d, wb_wait_q, wb_wait_d;
    logic              accept, kill_now;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ok_d      = 1'b0;
        wb_req_d  = wb_req_q;
        wb_wait_d = wb_wait_q;
        kill_now  = kill_q | bus.cpu_flush;
        accept    = state_q == IDLE && bus.cpu_valid && !bus.cpu_busy && !bus.cpu_flush;
        if (accept) begin
            addr_d  = bus.cpu_addr;
            size_d  = bus.cpu_size;
            strb_d  = bus.cpu_wstrb;
            wdata_d = bus.cpu_wdata;
`ifdef UNCACHE_WBUF_EN
            // a posted store retires to the CPU at once; the FSM stays in IDLE while it drains
            wb_req_d = bus.cpu_op;
            ok_d     = bus.cpu_op;
            state_d  = bus.cpu_op ? IDLE : RD_REQ;
`else
            state_d = bus.cpu_op ? WR_REQ : RD_REQ;
`endif
        end
`ifdef UNCACHE_WBUF_EN
        if (wb_req_q && bus.wr_rdy) begin
            wb_req_d  = 1'b0;
            wb_wait_d = 1'b1;
        end
        if (wb_wait_q && bus.wr_done)
            wb_wait_d = 1'b0;
`endif
        case (state_q)
            RD_REQ:  state_d = bus.rd_rdy ? RD_WAIT : RD_REQ;
            RD_WAIT: if (bus.ret_valid) begin
                state_d = IDLE;
                ok_d    = !kill_now;
                rdata_d = kill_now ? rdata_q : bus.ret_data;
            end
            WR_REQ:  state_d = bus.wr_rdy ? WR_WAIT : WR_REQ;
            WR_WAIT: if (bus.wr_done) begin
                state_d = IDLE;
                ok_d    = !kill_now;
            end
            default: ;
        endcase
        kill_d = state_d == IDLE ? 1'b0 : kill_now;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            kill_q    <= 1'b0;
            ok_q      <= 1'b0;
            wb_req_q  <= 1'b0;
            wb_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            kill_q    <= kill_d;
            ok_q      <= ok_d;
            wb_req_q  <= wb_req_d;
            wb_wait_q <= wb_wait_d;
        end
    end

    assign bus.cpu_busy    = state_q != IDLE || ok_q || wb_req_q || wb_wait_q;
    assign bus.cpu_data_ok = ok_q;
    assign bus.cpu_rdata   = rdata_q;
    assign bus.rd_req      = state_q == RD_REQ;
    assign bus.rd_addr     = addr_q;
    assign bus.rd_size     = size_q;
    assign bus.wr_req      = state_q == WR_REQ || wb_req_q;
    assign bus.wr_addr     = addr_q;
    assign bus.wr_size     = size_q;
    assign bus.wr_strb     = strb_q;
    assign bus.wr_data     = wdata_q;
endmodule

// File: tb/tb_dbus_uncache_resp.sv
// tb_dbus_uncache_resp: scoreboard bench for dbus_uncache_resp; expected CPU responses are queued at issue and matched on cpu_data_ok.
module tb_dbus_uncache_resp;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_ok = 0;
    int   t_flush = -1;
    logic [31:0] last_rd = '0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t okq[$];
    exp_t e;

    dbus_uncache_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dbus_uncache_resp #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus.cpu_flush = (cyc == t_flush);
    endtask

    always @(negedge clk) begin
        if (resetn && bus.cpu_data_ok) begin
            n_ok++;
            if (okq.size() == 0) chk("spurious_ok", 1, 0);
            else begin
                e = okq.pop_front();
                chk("ok_rdata", bus.cpu_rdata, e.data);
                chk("ok_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.cpu_busy && n < 40) begin
            tick();
            n++;
        end
        chk("idle_wait", bus.cpu_busy, 0);
    endtask

    // one complete transaction; fl is the flush cycle relative to acceptance (-1 = none)
    task automatic xact(input logic op, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] strb, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int rdy, input int rsp, input int fl, input logic early);
        int n, t0;
        wait_idle();
        t0 = cyc;
        t_flush = fl < 0 ? -1 : t0 + fl;
        bus.cpu_valid = 1'b1;
        bus.cpu_op    = op;
        bus.cpu_addr  = addr;
        bus.cpu_size  = size;
        bus.cpu_wstrb = strb;
        bus.cpu_wdata = wdata;
        if (fl < 0) okq.push_back('{op ? last_rd : rdata, t0 + 3 + rdy + rsp});
        if (fl < 0 && !op) last_rd = rdata;
        tick();
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
        n = 0;
        while (!(bus.rd_req || bus.wr_req) && n < 20) begin
            tick();
            n++;
        end
        chk("req_cyc", cyc, t0 + 1);
        chk("req_kind", {bus.rd_req, bus.wr_req}, op ? 2'b01 : 2'b10);
        chk("req_busy", bus.cpu_busy, 1);
        chk("req_addr", op ? bus.wr_addr : bus.rd_addr, addr);
        chk("req_size", op ? bus.wr_size : bus.rd_size, size);
        if (op) chk("req_strb_data", {bus.wr_strb, bus.wr_data}, {strb, wdata});
        for (int i = 0; i < rdy; i++) begin
            tick();
            chk("hold_busy", bus.cpu_busy, 1);
            chk("hold_req", {bus.rd_req | bus.wr_req, op ? bus.wr_addr : bus.rd_addr}, {1'b1, addr});
            if (op) chk("hold_data", {bus.wr_strb, bus.wr_data}, {strb, wdata});
        end
        bus.rd_rdy    = !op;
        bus.wr_rdy    = op;
        bus.ret_valid = early && !op;
        bus.wr_done   = early && op;
        bus.ret_data  = 32'hDEAD_BEEF;
        tick();
        bus.rd_rdy    = 1'b0;
        bus.wr_rdy    = 1'b0;
        bus.ret_valid = 1'b0;
        bus.wr_done   = 1'b0;
        for (int i = 0; i < rsp; i++) tick();
        bus.ret_valid = !op;
        bus.wr_done   = op;
        bus.ret_data  = rdata;
        tick();
        bus.ret_valid = 1'b0;
        bus.wr_done   = 1'b0;
        bus.ret_data  = $urandom;
        while (cyc < t0 + 3 + rdy + rsp) tick();
        t_flush = -1;
        bus.cpu_flush = 1'b0;
        chk("rdata_hold", bus.cpu_rdata, last_rd);
    endtask

    initial begin
        int t0, ok0;
        bus.cpu_valid = 0; bus.cpu_op = 0; bus.cpu_addr = 0; bus.cpu_size = 0;
        bus.cpu_wstrb = 0; bus.cpu_wdata = 0; bus.cpu_flush = 0;
        bus.rd_rdy = 0; bus.ret_valid = 0; bus.ret_data = 0; bus.wr_rdy = 0; bus.wr_done = 0;
        repeat (3) tick();
        chk("rst_ctrl", {bus.cpu_busy, bus.cpu_data_ok, bus.rd_req, bus.wr_req}, 4'b0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_addr", {bus.rd_addr, bus.wr_addr}, 0);
        resetn = 1'b1;
        tick();

        xact(0, 32'hBFAF_8000, 2, 4'hF, 0, 32'h1234_5678, 0, 0, -1, 0);
        xact(0, 32'hBFAF_8004, 1, 4'h3, 0, 32'hA5A5_0F0F, 2, 3, -1, 1);
`ifndef UNCACHE_WBUF_EN
        xact(1, 32'hBFD0_0003, 0, 4'b1000, 32'hAB00_0000, 0, 3, 0, -1, 0);
        xact(1, 32'hBFD0_0010, 2, 4'hF, 32'hCAFE_F00D, 0, 1, 2, -1, 1);
`endif
        xact(0, 32'hBFAF_8008, 2, 4'hF, 0, 32'h7777_8888, 0, 0, 2, 0);
        xact(0, 32'hBFAF_800C, 2, 4'hF, 0, 32'h0102_0304, 0, 1, 3, 0);
        xact(0, 32'hBFAF_8010, 2, 4'hF, 0, 32'h5566_7788, 0, 0, -1, 0);
`ifndef UNCACHE_WBUF_EN
        ok0 = n_ok;
        xact(0, 32'hBFC0_0100, 2, 4'hF, 0, 32'h1111_2222, 0, 0, -1, 0);
        xact(1, 32'hBFC0_0104, 2, 4'hF, 32'h3333_4444, 0, 0, 0, -1, 0);
        xact(0, 32'hBFC0_0108, 0, 4'h1, 0, 32'h5555_6666, 1, 0, -1, 0);
        chk("b2b_ok_count", n_ok - ok0, 3);
`else
        wait_idle();
        t0 = cyc;
        bus.cpu_valid = 1; bus.cpu_op = 1; bus.cpu_addr = 32'hBFD0_0020;
        bus.cpu_size = 2; bus.cpu_wstrb = 4'hF; bus.cpu_wdata = 32'h55AA_1234;
        okq.push_back('{last_rd, t0 + 1});
        tick();
        chk("wb_wr_req", {bus.wr_req, bus.wr_addr}, {1'b1, 32'hBFD0_0020});
        chk("wb_wr_data", bus.wr_data, 32'h55AA_1234);
        chk("wb_busy", bus.cpu_busy, 1);
        bus.cpu_op = 0;
        bus.wr_rdy = 1;
        tick();
        bus.wr_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            chk("wb_hold_rd", {bus.rd_req, bus.cpu_busy}, 2'b01);
            tick();
        end
        bus.wr_done = 1;
        chk("wb_hold_rd", bus.rd_req, 0);
        tick();
        bus.wr_done = 0;
        chk("wb_busy_clr", bus.cpu_busy, 0);
        okq.push_back('{32'h0BAD_F00D, t0 + 11});
        last_rd = 32'h0BAD_F00D;
        tick();
        bus.cpu_valid = 0;
        chk("wb_rd_req", {bus.rd_req, bus.rd_addr}, {1'b1, 32'hBFD0_0020});
        chk("wb_rd_cyc", cyc, t0 + 9);
        bus.rd_rdy = 1;
        tick();
        bus.rd_rdy = 0; bus.ret_valid = 1; bus.ret_data = 32'h0BAD_F00D;
        tick();
        bus.ret_valid = 0;
        tick();
`endif
        wait_idle();
        bus.cpu_valid = 1; bus.cpu_op = 0; bus.cpu_addr = 32'hBFC0_0010; bus.cpu_size = 2;
        tick();
        bus.cpu_valid = 0;
        bus.rd_rdy = 1;
        tick();
        bus.rd_rdy = 0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_ctrl", {bus.cpu_busy, bus.cpu_data_ok, bus.rd_req, bus.wr_req}, 4'b0);
        chk("rst_mid_rdata", bus.cpu_rdata, 0);
        chk("rst_mid_addr", bus.rd_addr, 0);
        last_rd = '0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        xact(0, 32'hBFC0_0014, 2, 4'hF, 0, 32'h9ABC_DEF0, 1, 1, -1, 0);
        repeat (3) tick();
        chk("okq_empty", okq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
